read_string_loader: RTL and testbench
=====================================

# read_string_loader

Syscall-side writer that fills data memory with a null-terminated string taken from a byte input stream; the counterpart of the print-string path, which reads such strings out. It sits beside the data-memory port, is kicked by the syscall decoder with the buffer address ($a0) and length ($a1), packs bytes big-endian into 32-bit words (first character in [31:24]), issues one word write per filled word, and appends the 0x00 terminator.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- buf_addr  in  32  buffer byte address; bits [1:0] ignored (word-aligned)
- buf_len  in  32  buffer size in bytes including terminator
- char_valid  in  1  input byte available
- char_data  in  8  input byte
- char_ready  out  1  block accepts byte this cycle
- mem_write  out  1  data-memory write strobe, one cycle per word
- mem_addr  out  32  word-aligned byte address of write
- mem_write_data  out  32  packed word
- busy  out  1  high from start acceptance until DONE exits
- done  out  1  one-cycle completion pulse
- count  out  32  characters stored, terminator excluded

## Operation
- States: IDLE, RECV, WRITE, PAD, TERM, DONE.
- IDLE: start=1 latches ptr={buf_addr[31:2],2'b00}, limit=buf_len, clears word, slot=0, count=0, stop=0. buf_len==0 -> DONE (no write); buf_len==1 -> TERM; else RECV.
- RECV: char_ready=1. Handshake = char_valid & char_ready.
  - char_data==0x00: not stored -> TERM.
  - else byte stored at slot (slot 0 -> [31:24]), count+1, slot+1 (mod 4). stop set if count+1 == limit-1 or newline rule (Configuration) fires.
  - slot was 3 -> WRITE; else stop -> TERM; else stay.
- WRITE: mem_write=1, mem_addr=ptr, data=word; then ptr+=4, word=0, slot=0. Next: stop ? PAD : RECV.
- PAD: one idle cycle, no write -> TERM. Guarantees mem_write never high two cycles in a row (memory strobes on edge).
- TERM: mem_write=1, mem_addr=ptr, data=word (terminator and trailing bytes already zero; a fresh word writes 32'h0). -> DONE.
- DONE: done=1, busy=1 -> IDLE.
- Whole words always written: bytes after terminator in the last word become 0x00.
- ptr wraps modulo 2^32; no range checking.
- start while busy ignored; char_valid outside RECV ignored.

## Timing
- Reset values: char_ready=0, mem_write=0, mem_addr=0, mem_write_data=0, busy=0, done=0, count=0; state IDLE.
- start at cycle N -> busy=1 at N+1; RECV at N+1 for buf_len>=2.
- Up to one byte per cycle; char_ready drops for the WRITE cycle after every 4th byte.
- Outputs registered; mem_write/mem_addr/mem_write_data change together.
- Termination latency: terminating byte accepted at cycle M -> TERM write at M+1 (M+3 via WRITE,PAD when it filled slot 3), done at next cycle after TERM.
- count valid and stable from done until next accepted start.
- reset_n low mid-operation: IDLE next edge, all outputs to reset values; words already written stay.

## Configuration
- READ_STRING_NEWLINE_TERM_EN defined: char 0x0A is stored, counted, and sets stop (SPIM read_string semantics).
- Undefined: 0x0A is an ordinary character; only 0x00 or length limit terminate.

## Test plan
- buf_addr=0x100, buf_len=16, bytes "Hi",0x00 -> one write @0x100 = 0x48690000, count=2, done one cycle later.
- buf_addr=0x200, buf_len=16, "ABCD",0x00 -> write @0x200=0x41424344, PAD cycle, write @0x204=0x00000000, count=4; mem_write never high two consecutive cycles.
- buf_len=4, stream "WXYZ…" -> 3 bytes taken, write @addr=0x57585900, char_ready=0 after third byte, count=3.
- READ_STRING_NEWLINE_TERM_EN on: "ok\n" -> 0x6F6B0A00, count=3; off: "ok\nA",0x00 -> 0x6F6B0A41 then 0x00000000, count=4.
- buf_len=0 -> no mem_write, done 2 cycles after start; buf_len=1 -> single write 0x00000000.
- reset_n low after 5 bytes of "abcdefg" at 0x300 -> outputs reset next edge, word @0x300=0x61626364 retained, no further writes; new start works.

Source files
------------

// File: rtl/read_string_loader.sv
// Syscall-side string reader: packs input bytes big-endian into words and writes a
// null-terminated string to data memory. Optional macro: READ_STRING_NEWLINE_TERM_EN.
module read_string_loader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] buf_addr,
    input  logic [31:0] buf_len,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] count
);

    typedef enum logic [2:0] {StIdle, StRecv, StWrite, StPad, StTerm, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] limit_q, limit_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  slot_q, slot_d;
    logic [31:0] count_q, count_d;
    logic        stop_q, stop_d;
    logic        char_ready_q, char_ready_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        newline_hit;

`ifdef READ_STRING_NEWLINE_TERM_EN
    assign newline_hit = (char_data == 8'h0A);
`else
    assign newline_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        limit_d = limit_q;
        word_d  = word_q;
        slot_d  = slot_q;
        count_d = count_q;
        stop_d  = stop_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d   = {buf_addr[31:2], 2'b00};
                    limit_d = buf_len;
                    word_d  = 32'h0;
                    slot_d  = 2'd0;
                    count_d = 32'h0;
                    stop_d  = 1'b0;
                    if (buf_len == 32'd0)      state_d = StDone;
                    else if (buf_len == 32'd1) state_d = StTerm;
                    else                       state_d = StRecv;
                end
            end
            StRecv: begin
                if (char_valid) begin
                    if (char_data == 8'h00) begin
                        state_d = StTerm;
                    end else begin
                        unique case (slot_q)
                            2'd0: word_d[31:24] = char_data;
                            2'd1: word_d[23:16] = char_data;
                            2'd2: word_d[15:8]  = char_data;
                            2'd3: word_d[7:0]   = char_data;
                        endcase
                        count_d = count_q + 32'd1;
                        slot_d  = slot_q + 2'd1;
                        // Leave room for the terminator inside the buffer.
                        stop_d  = (count_d == limit_q - 32'd1) || newline_hit;
                        if (slot_q == 2'd3) state_d = StWrite;
                        else if (stop_d)    state_d = StTerm;
                    end
                end
            end
            StWrite: begin
                ptr_d   = ptr_q + 32'd4;
                word_d  = 32'h0;
                slot_d  = 2'd0;
                state_d = stop_q ? StPad : StRecv;
            end
            StPad:   state_d = StTerm;
            StTerm:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered off the next state so they line up with it.
        char_ready_d = (state_d == StRecv);
        mem_write_d  = (state_d == StWrite) || (state_d == StTerm);
        mem_addr_d   = mem_write_d ? ptr_d  : mem_addr_q;
        mem_data_d   = mem_write_d ? word_d : mem_data_q;
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            ptr_q        <= 32'h0;
            limit_q      <= 32'h0;
            word_q       <= 32'h0;
            slot_q       <= 2'd0;
            count_q      <= 32'h0;
            stop_q       <= 1'b0;
            char_ready_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_data_q   <= 32'h0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            limit_q      <= limit_d;
            word_q       <= word_d;
            slot_q       <= slot_d;
            count_q      <= count_d;
            stop_q       <= stop_d;
            char_ready_q <= char_ready_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign char_ready     = char_ready_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign count          = count_q;

endmodule

// File: tb/tb_read_string_loader.sv
// Scoreboard bench for read_string_loader: expected writes/counts are queued by the
// stimulus, a negedge monitor pops and compares them as the DUT produces them.
module tb_read_string_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] buf_addr = 32'h0;
    logic [31:0] buf_len = 32'h0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h0;
    logic        char_ready;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        busy;
    logic        done;
    logic [31:0] count;

    read_string_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .buf_addr       (buf_addr),
        .buf_len        (buf_len),
        .char_valid     (char_valid),
        .char_data      (char_data),
        .char_ready     (char_ready),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .busy           (busy),
        .done           (done),
        .count          (count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    logic        prev_wr = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_cnt[$];
    logic [7:0]  stream[$];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_wr   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (mem_write) begin
                chk("no_back_to_back_write", {31'h0, prev_wr}, 32'h0);
                if (exp_addr.size() == 0) begin
                    chk("unexpected_write_addr", mem_addr, 32'hxxxx_xxxx);
                end else begin
                    chk("write_addr", mem_addr, exp_addr.pop_front());
                    chk("write_data", mem_write_data, exp_data.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_single_pulse", {31'h0, prev_done}, 32'h0);
                if (exp_cnt.size() == 0) chk("unexpected_done", count, 32'hxxxx_xxxx);
                else                     chk("count_at_done", count, exp_cnt.pop_front());
            end
            prev_wr   = mem_write;
            prev_done = done;
        end
    end

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    // Issue start, then feed stream bytes until done (or stop_after bytes accepted).
    task automatic run(input logic [31:0] addr, input logic [31:0] len,
                       input int stop_after, output int consumed);
        int i;
        int cyc;
        int done_start;
        logic acc;
        @(negedge clk);
        start = 1'b1; buf_addr = addr; buf_len = len; char_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        i = 0; cyc = 0; acc = 1'b0; done_start = done_cnt;
        while (done_cnt == done_start && cyc < 200) begin
            if (acc) i++;
            if (stop_after != 0 && i == stop_after) break;
            char_valid = (i < stream.size());
            char_data  = char_valid ? stream[i] : 8'h00;
            acc = char_ready && char_valid;
            @(negedge clk);
            cyc++;
        end
        char_valid = 1'b0;
        chk("run_within_budget", {31'h0, cyc < 200}, 32'h1);
        consumed = i;
    endtask

    task automatic check_reset_outputs();
        chk("rst_char_ready", {31'h0, char_ready}, 32'h0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data", mem_write_data, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_count", count, 32'h0);
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;
        @(negedge clk);

        // "Hi"
        stream = '{8'h48, 8'h69, 8'h00};
        push_wr(32'h100, 32'h4869_0000); exp_cnt.push_back(32'd2);
        run(32'h100, 32'd16, 0, c);
        chk("hi_consumed", c, 32'd3);

        // Full word, then terminator in a fresh word
        stream = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h00};
        push_wr(32'h200, 32'h4142_4344); push_wr(32'h204, 32'h0); exp_cnt.push_back(32'd4);
        run(32'h200, 32'd16, 0, c);

        // Length limit: only 3 of 4+ bytes taken
        stream = '{8'h57, 8'h58, 8'h59, 8'h5A, 8'h5A};
        push_wr(32'h400, 32'h5758_5900); exp_cnt.push_back(32'd3);
        run(32'h400, 32'd4, 0, c);
        chk("limit_consumed", c, 32'd3);

        // Newline handling
        stream = '{8'h6F, 8'h6B, 8'h0A, 8'h41, 8'h00};
`ifdef READ_STRING_NEWLINE_TERM_EN
        push_wr(32'h500, 32'h6F6B_0A00); exp_cnt.push_back(32'd3);
        run(32'h500, 32'd16, 0, c);
        chk("newline_consumed", c, 32'd3);
`else
        push_wr(32'h500, 32'h6F6B_0A41); push_wr(32'h504, 32'h0); exp_cnt.push_back(32'd4);
        run(32'h500, 32'd16, 0, c);
        chk("newline_consumed", c, 32'd5);
`endif

        // Zero and one byte buffers; unaligned address rounds down
        stream = {};
        exp_cnt.push_back(32'd0);
        run(32'h800, 32'd0, 0, c);
        push_wr(32'h900, 32'h0); exp_cnt.push_back(32'd0);
        run(32'h903, 32'd1, 0, c);

        // Limit hit on the 4th byte: WRITE, PAD, then terminator word
        stream = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        push_wr(32'h600, 32'h6162_6364); push_wr(32'h604, 32'h0); exp_cnt.push_back(32'd4);
        run(32'h600, 32'd5, 0, c);
        chk("limit_word_consumed", c, 32'd4);

        // Reset after 5 bytes: first word stays written, nothing else follows
        stream = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h00};
        push_wr(32'h300, 32'h6162_6364);
        run(32'h300, 32'd16, 5, c);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_write_after_reset", {31'h0, mem_write}, 32'h0);

        stream = '{8'h48, 8'h69, 8'h00};
        push_wr(32'h700, 32'h4869_0000); exp_cnt.push_back(32'd2);
        run(32'h700, 32'd16, 0, c);
        chk("count_stable_after_done", count, 32'd2);

        repeat (4) @(negedge clk);
        chk("writes_outstanding", exp_addr.size(), 32'd0);
        chk("dones_outstanding", exp_cnt.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
